// File: rtl/seven_segment_scan_decoder_if.sv
// rtl/seven_segment_scan_decoder_if.sv - scanned 7-segment bus in, decoded digit state out
interface seven_segment_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic                    err_pattern;
  logic                    err_anode;

  modport master (
    output seg_in, an_in,
    input  digits, dp, digit_valid, update, err_pattern, err_anode
  );

  modport slave (
    input  seg_in, an_in,
    output digits, dp, digit_valid, update, err_pattern, err_anode
  );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - glitch-filtered decoder of a multiplexed active-low 7-segment bus
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seven_segment_scan_decoder_if.slave bus
);
  localparam int         W      = 8 + NUM_DIGITS;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, COMMIT, LOCKED} state_t;

  logic [W-1:0]            sync1, sync2, prev;
  logic [7:0]              cnt;
  state_t                  state, state_next;
  logic                    commit;
  logic [NUM_DIGITS-1:0]   cur_an;
  logic [7:0]              cur_seg;
  logic                    all_off, one_low;
  logic [4:0]              decoded;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   dp_r, valid_r;
  logic                    update_r, err_pattern_r, err_anode_r;

  // Returns {hit, nibble} for a gfedcba active-low pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    decode = 5'h00;
    case (p)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // The FSM acts on prev/cnt: prev is the filtered word, cnt its run length.
  assign cur_an  = prev[W-1:8];
  assign cur_seg = prev[7:0];
  assign all_off = &cur_an;
  assign one_low = $onehot(~cur_an);
  assign decoded = decode(cur_seg[6:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= {bus.an_in, bus.seg_in};
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        cnt <= 8'd1;
      end else if (cnt < STABLE) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // cnt == 1 outside TRACK means the word changed on the previous edge.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (!all_off) state_next = TRACK;
      end
      TRACK: begin
        if (all_off) begin
          state_next = IDLE;
        end else if (cnt == STABLE) begin
          state_next = COMMIT;
          commit     = 1'b1;
        end
      end
      COMMIT, LOCKED: begin
        if (cnt == 8'd1) state_next = all_off ? IDLE : TRACK;
        else             state_next = LOCKED;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r      <= '0;
      dp_r          <= '0;
      valid_r       <= '0;
      update_r      <= 1'b0;
      err_pattern_r <= 1'b0;
      err_anode_r   <= 1'b0;
    end else begin
      update_r      <= 1'b0;
      err_pattern_r <= 1'b0;
      err_anode_r   <= 1'b0;
      if (commit) begin
        if (!one_low) begin
          err_anode_r <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!cur_an[i]) begin
              dp_r[i] <= ~cur_seg[7];
              if (decoded[4]) begin
                digits_r[4*i +: 4] <= decoded[3:0];
                valid_r[i]         <= 1'b1;
              end else begin
                valid_r[i] <= 1'b0;
              end
            end
          end
          if (decoded[4]) update_r      <= 1'b1;
          else            err_pattern_r <= 1'b1;
        end
      end
    end
  end

  assign bus.digits      = digits_r;
  assign bus.dp          = dp_r;
  assign bus.digit_valid = valid_r;
  assign bus.update      = update_r;
  assign bus.err_pattern = err_pattern_r;
  assign bus.err_anode   = err_anode_r;
endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;
  localparam int ND     = 4;
  localparam int STABLE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference: every run of >= STABLE identical samples with some anode low
  // commits once, three edges after the sample that completes the run.
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_valid;
  logic        m_upd, m_errp, m_erra;
  logic [11:0] run_w;
  int          run_len;
  logic        pipe_v [3];
  logic [11:0] pipe_w [3];

  task automatic model_commit(input logic [11:0] w);
    int idx;
    int val;
    idx = -1;
    val = -1;
    if ($countones(~w[11:8]) != 1) begin
      m_erra = 1'b1;
    end else begin
      for (int i = 0; i < ND; i++) if (!w[8+i]) idx = i;
      for (int v = 0; v < 16; v++) if (tbl[v] == w[6:0]) val = v;
      m_dp[idx] = ~w[7];
      if (val >= 0) begin
        m_digits[4*idx +: 4] = 4'(val);
        m_valid[idx] = 1'b1;
        m_upd = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        m_errp = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits = '0; m_dp = '0; m_valid = '0;
      m_upd = 0; m_errp = 0; m_erra = 0;
      run_len = 0; run_w = '0;
      for (int i = 0; i < 3; i++) begin pipe_v[i] = 0; pipe_w[i] = '0; end
    end else begin
      m_upd = 0; m_errp = 0; m_erra = 0;
      if (pipe_v[2]) model_commit(pipe_w[2]);
      pipe_v[2] = pipe_v[1]; pipe_w[2] = pipe_w[1];
      pipe_v[1] = pipe_v[0]; pipe_w[1] = pipe_w[0];
      pipe_v[0] = 0;
      if (run_len > 0 && {bus.an_in, bus.seg_in} == run_w) begin
        run_len++;
      end else begin
        run_w = {bus.an_in, bus.seg_in};
        run_len = 1;
      end
      if (run_len == STABLE && !(&run_w[11:8])) begin
        pipe_v[0] = 1;
        pipe_w[0] = run_w;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int n_upd, n_errp, n_erra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n_upd  += int'(bus.update);
    n_errp += int'(bus.err_pattern);
    n_erra += int'(bus.err_anode);
    chk("model_digits", 32'(bus.digits), 32'(m_digits));
    chk("model_dp", 32'(bus.dp), 32'(m_dp));
    chk("model_valid", 32'(bus.digit_valid), 32'(m_valid));
    chk("model_update", 32'(bus.update), 32'(m_upd));
    chk("model_err_pattern", 32'(bus.err_pattern), 32'(m_errp));
    chk("model_err_anode", 32'(bus.err_anode), 32'(m_erra));
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg);
    bus.an_in = an;
    bus.seg_in = seg;
  endtask

  task automatic clr_counts();
    n_upd = 0; n_errp = 0; n_erra = 0;
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    int          upd;
    int          errp;
    int          erra;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first;
    logic [3:0] an;
    logic [7:0] seg;

    vecs[0] = '{4'b1110, 8'b1_0110000, 16'h0003, 4'b0000, 4'b0001, 1, 0, 0};
    vecs[1] = '{4'b1101, 8'b0_0001000, 16'h00A3, 4'b0010, 4'b0011, 1, 0, 0};
    vecs[2] = '{4'b1101, 8'b1_1111111, 16'h00A3, 4'b0000, 4'b0001, 0, 1, 0};
    vecs[3] = '{4'b1100, 8'b1_1111001, 16'h00A3, 4'b0000, 4'b0001, 0, 0, 1};
    vecs[4] = '{4'b1111, 8'b1_0000000, 16'h00A3, 4'b0000, 4'b0001, 0, 0, 0};
    vecs[5] = '{4'b0111, 8'b1_0001110, 16'hF0A3, 4'b0000, 4'b1001, 1, 0, 0};

    drive(4'hF, 8'hFF);
    clr_counts();
    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(bus.digits), 32'h0);
    chk("reset_valid", 32'(bus.digit_valid), 32'h0);
    rst_n = 1'b1;

    // First-commit latency: pulse registered at edge 2 + STABLE + 1.
    drive(4'b1110, 8'b1_0110000);
    first = 0;
    clr_counts();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.update && first == 0) first = k;
    end
    chk("latency_edge", 32'(first), 32'd11);
    chk("latency_pulses", 32'(n_upd), 32'd1);
    chk("latency_digit0", 32'(bus.digits[3:0]), 32'h3);
    chk("latency_dp0", 32'(bus.dp[0]), 32'h0);
    chk("latency_valid0", 32'(bus.digit_valid[0]), 32'h1);

    drive(4'hF, 8'hFF);
    repeat (12) step();

    foreach (vecs[i]) begin
      drive(vecs[i].an, vecs[i].seg);
      clr_counts();
      repeat (20) step();
      chk($sformatf("vec%0d_digits", i), 32'(bus.digits), 32'(vecs[i].digits));
      chk($sformatf("vec%0d_dp", i), 32'(bus.dp), 32'(vecs[i].dp));
      chk($sformatf("vec%0d_valid", i), 32'(bus.digit_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_update", i), 32'(n_upd), 32'(vecs[i].upd));
      chk($sformatf("vec%0d_err_pattern", i), 32'(n_errp), 32'(vecs[i].errp));
      chk($sformatf("vec%0d_err_anode", i), 32'(n_erra), 32'(vecs[i].erra));
    end

    // Full 4-digit scan, two frames.
    clr_counts();
    for (int f = 0; f < 2; f++) begin
      drive(4'b1110, 8'b1_1111001); repeat (16) step();
      drive(4'b1101, 8'b1_0001000); repeat (16) step();
      drive(4'b1011, 8'b0_1000110); repeat (16) step();
      drive(4'b0111, 8'b1_0001110); repeat (16) step();
    end
    drive(4'hF, 8'hFF);
    repeat (12) step();
    chk("scan_digits", 32'(bus.digits), 32'hFCA1);
    chk("scan_dp", 32'(bus.dp), 32'b0100);
    chk("scan_valid", 32'(bus.digit_valid), 32'hF);
    chk("scan_updates", 32'(n_upd), 32'd8);

    // Short glitches from idle never commit.
    clr_counts();
    drive(4'b1110, 8'b1_0010010); repeat (5) step();
    drive(4'b1101, 8'b1_0000000); repeat (5) step();
    drive(4'b1110, 8'b1_0010010); repeat (7) step();
    drive(4'hF, 8'hFF); repeat (15) step();
    chk("glitch_pulses", 32'(n_upd + n_errp + n_erra), 32'd0);
    chk("glitch_digits", 32'(bus.digits), 32'hFCA1);

    for (int v = 0; v < 16; v++) begin
      seg = {1'b1, tbl[v]};
      drive(4'b1110, seg);
      repeat (12) step();
      chk($sformatf("table_%0h", v), 32'(bus.digits[3:0]), 32'(v));
    end

    // Asynchronous reset mid-TRACK.
    drive(4'b1011, 8'b1_0100100);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_digits", 32'(bus.digits), 32'h0);
    chk("rst_dp", 32'(bus.dp), 32'h0);
    chk("rst_valid", 32'(bus.digit_valid), 32'h0);
    chk("rst_pulses", 32'({bus.update, bus.err_pattern, bus.err_anode}), 32'h0);
    drive(4'hF, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    repeat (20) step();
    chk("post_rst_pulses", 32'(n_upd + n_errp + n_erra), 32'd0);

    for (int r = 0; r < 300; r++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: an = ~(4'b0001 << $urandom_range(0, 3));
        4:          an = 4'hF;
        default:    an = ~(4'b0011 << $urandom_range(0, 2));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        seg[7]   = 1'($urandom_range(0, 1));
        seg[6:0] = tbl[$urandom_range(0, 15)];
      end else begin
        seg = 8'($urandom);
      end
      drive(an, seg);
      repeat ($urandom_range(1, 14)) step();
    end
    drive(4'hF, 8'hFF);
    repeat (15) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
